sqrt_iter: RTL and testbench

SQRT_ITER -- requirements
Module: sqrt_iter

---
 rtl/sqrt_iter_if.sv | 27 ++
 rtl/sqrt_iter.sv | 105 ++++++++++
 tb/tb_sqrt_iter.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sqrt_iter_if.sv
// sqrt_iter_if: operand/result handshake bundle for the iterative square-root block
interface sqrt_iter_if #(
    parameter int IN_WIDTH  = 32,
    parameter int FRAC_OUT  = 0,
    parameter int TAG_WIDTH = 4
);
    localparam int OUT_WIDTH = IN_WIDTH / 2 + FRAC_OUT;
    localparam int REM_WIDTH = OUT_WIDTH + 1;
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in;
    logic [TAG_WIDTH-1:0] in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out;
    logic [REM_WIDTH-1:0] rem;
    logic [TAG_WIDTH-1:0] out_tag;
    logic                 out_sat;
    modport master (
        output in_valid, in, in_tag, out_ready,
        input  in_ready, out_valid, out, rem, out_tag, out_sat
    );
    modport slave (
        input  in_valid, in, in_tag, out_ready,
        output in_ready, out_valid, out, rem, out_tag, out_sat
    );
endinterface

// File: rtl/sqrt_iter.sv
// sqrt_iter: restoring digit-recurrence square root, one root bit per cycle, with tag and optional rounding
module sqrt_iter #(
    parameter int IN_WIDTH  = 32,
    parameter int FRAC_OUT  = 0,
    parameter int TAG_WIDTH = 4,
    parameter int ROUND     = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    output logic       busy,
    sqrt_iter_if.slave sif
);
    localparam int OUT_WIDTH = IN_WIDTH / 2 + FRAC_OUT;
    localparam int REM_WIDTH = OUT_WIDTH + 1;
    localparam int X_WIDTH   = 2 * OUT_WIDTH;
    localparam int CNT_WIDTH = $clog2(OUT_WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, FIN, DONE} state_t;
    state_t               r_state, w_next;
    logic [X_WIDTH-1:0]   r_x;
    logic [OUT_WIDTH-1:0] r_root;
    logic [REM_WIDTH-1:0] r_acc;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [TAG_WIDTH-1:0] r_tag;
    logic [OUT_WIDTH-1:0] r_out;
    logic [REM_WIDTH-1:0] r_rem;
    logic [TAG_WIDTH-1:0] r_out_tag;
    logic                 r_sat;
    logic                 w_accept;
    logic [X_WIDTH-1:0]   w_xin;
    logic [REM_WIDTH+1:0] w_cat;
    logic [REM_WIDTH+1:0] w_sub;
    logic                 w_ge;
    logic [REM_WIDTH-1:0] w_acc_n;
    logic                 w_up;
    logic                 w_sat;
    assign sif.in_ready  = !reset && !flush && (r_state == IDLE || (r_state == DONE && sif.out_ready));
    assign w_accept      = sif.in_valid && sif.in_ready;
    assign w_xin         = X_WIDTH'(sif.in) << (2 * FRAC_OUT);
    // Trial subtraction: bring down the next radicand pair and test 4*root+1 against it
    assign w_cat         = {r_acc, r_x[X_WIDTH-1 -: 2]};
    assign w_sub         = {1'b0, r_root, 2'b01};
    assign w_ge          = w_cat >= w_sub;
    assign w_acc_n       = REM_WIDTH'(w_ge ? w_cat - w_sub : w_cat);
    // Round up when the remainder exceeds the root, unless the root is already all ones
    assign w_up          = (ROUND == 1) && (r_acc > {1'b0, r_root});
    assign w_sat         = w_up && (&r_root);
    assign sif.out_valid = r_state == DONE;
    assign sif.out       = r_out;
    assign sif.rem       = r_rem;
    assign sif.out_tag   = r_out_tag;
    assign sif.out_sat   = r_sat;
    assign busy          = r_state != IDLE;
    // State register
    always_ff @(posedge clk) begin
        r_state <= reset ? IDLE : w_next;
    end
    // Next-state: flush always returns to IDLE; a DONE handshake chains straight into RUN on accept
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? RUN : IDLE;
            RUN:     w_next = (r_cnt == '0) ? FIN : RUN;
            FIN:     w_next = DONE;
            DONE:    w_next = sif.out_ready ? (w_accept ? RUN : IDLE) : DONE;
            default: w_next = IDLE;
        endcase
        if (flush) w_next = IDLE;
    end
    // Working datapath: load on accept, one recurrence step per RUN cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x    <= '0;
            r_root <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_tag  <= '0;
        end else if (w_accept) begin
            r_x    <= w_xin;
            r_root <= '0;
            r_acc  <= '0;
            r_cnt  <= CNT_WIDTH'(OUT_WIDTH - 1);
            r_tag  <= sif.in_tag;
        end else if (r_state == RUN && !flush) begin
            r_x    <= r_x << 2;
            r_root <= {r_root[OUT_WIDTH-2:0], w_ge};
            r_acc  <= w_acc_n;
            r_cnt  <= r_cnt - 1'b1;
        end
    end
    // Result registers: written only in FIN so earlier results persist through a new RUN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out     <= '0;
            r_rem     <= '0;
            r_out_tag <= '0;
            r_sat     <= 1'b0;
        end else if (r_state == FIN && !flush) begin
            r_out     <= r_root + OUT_WIDTH'(w_up && !w_sat);
            r_rem     <= r_acc;
            r_out_tag <= r_tag;
            r_sat     <= w_sat;
        end
    end
endmodule

// File: tb/tb_sqrt_iter.sv
// tb_sqrt_iter: scoreboard bench for sqrt_iter (truncating, rounding and fractional variants)
module tb_sqrt_iter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic busy0, busy1, busy2;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;
    typedef struct packed {
        logic [31:0] root;
        logic [32:0] rem;
        logic [3:0]  tag;
        logic [31:0] rnd;
        logic        sat;
    } exp_t;
    exp_t sb[$];
    exp_t q2[$];
    sqrt_iter_if #(.IN_WIDTH(32), .FRAC_OUT(0), .TAG_WIDTH(4)) if0 ();
    sqrt_iter_if #(.IN_WIDTH(32), .FRAC_OUT(0), .TAG_WIDTH(4)) if1 ();
    sqrt_iter_if #(.IN_WIDTH(32), .FRAC_OUT(4), .TAG_WIDTH(4)) if2 ();
    sqrt_iter #(.IN_WIDTH(32), .FRAC_OUT(0), .TAG_WIDTH(4), .ROUND(0)) d0 (.clk(clk), .reset(reset), .flush(flush), .busy(busy0), .sif(if0));
    sqrt_iter #(.IN_WIDTH(32), .FRAC_OUT(0), .TAG_WIDTH(4), .ROUND(1)) d1 (.clk(clk), .reset(reset), .flush(flush), .busy(busy1), .sif(if1));
    sqrt_iter #(.IN_WIDTH(32), .FRAC_OUT(4), .TAG_WIDTH(4), .ROUND(0)) d2 (.clk(clk), .reset(reset), .flush(flush), .busy(busy2), .sif(if2));
    assign if1.in_valid  = if0.in_valid;
    assign if1.in        = if0.in;
    assign if1.in_tag    = if0.in_tag;
    assign if1.out_ready = if0.out_ready;

    function automatic exp_t model(longint unsigned x, int ow, logic [3:0] tag);
        exp_t e;
        longint unsigned r, rm, mx;
        r = longint'($sqrt(real'(x)));
        while (r * r > x) r--;
        while ((r + 1) * (r + 1) <= x) r++;
        rm = x - r * r;
        mx = (64'd1 << ow) - 1;
        e.root = 32'(r);
        e.rem  = 33'(rm);
        e.tag  = tag;
        e.sat  = (rm > r) && (r == mx);
        e.rnd  = 32'(((rm > r) && (r != mx)) ? r + 1 : r);
        return e;
    endfunction

    task automatic send0(input logic [31:0] x, input logic [3:0] tag, input bit push);
        int t = 0;
        #1;
        while (!if0.in_ready && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        checks++;
        if (t >= 100) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%b want 1", if0.in_ready);
        end
        if0.in_valid = 1'b1;
        if0.in       = x;
        if0.in_tag   = tag;
        if (push) sb.push_back(model(longint'(x), 16, tag));
        @(negedge clk);
        if0.in_valid = 1'b0;
    endtask

    task automatic wait_valid0(output int n);
        n = 0;
        while (!if0.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({if0.in_ready, if0.out_valid, busy0, if0.out_sat, if0.out, if0.rem, if0.out_tag} !== '0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b busy=%b sat=%b out=%h rem=%h tag=%h want all 0",
                     if0.in_ready, if0.out_valid, busy0, if0.out_sat, if0.out, if0.rem, if0.out_tag);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (if0.in_ready !== 1'b1 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b busy=%b want 1 0", if0.in_ready, busy0);
        end
    endtask

    task automatic test_basic;
        logic [31:0] xs [5] = '{32'd24, 32'hFFFF_FFFF, 32'd0, 32'd1000000, 32'd3};
        int   n;
        exp_t e;
        if0.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            logic [31:0] x;
            x = (i < 5) ? xs[i] : $urandom;
            send0(x, 4'(i + 3), 1'b1);
            wait_valid0(n);
            e = sb.pop_front();
            checks++;
            if (n !== 17 || if1.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL basic_latency[%0d]: got %0d cycles (rnd vld=%b) want 17", i, n, if1.out_valid);
            end
            checks++;
            if ({if0.out, if0.rem, if0.out_tag, if0.out_sat} !== {e.root[15:0], e.rem[16:0], e.tag, 1'b0}) begin
                errors++;
                $display("FAIL basic_trunc[%0d] x=%h: got out=%h rem=%h tag=%h sat=%b want out=%h rem=%h tag=%h sat=0",
                         i, x, if0.out, if0.rem, if0.out_tag, if0.out_sat, e.root[15:0], e.rem[16:0], e.tag);
            end
            checks++;
            if ({if1.out, if1.rem, if1.out_sat} !== {e.rnd[15:0], e.rem[16:0], e.sat}) begin
                errors++;
                $display("FAIL basic_round[%0d] x=%h: got out=%h rem=%h sat=%b want out=%h rem=%h sat=%b",
                         i, x, if1.out, if1.rem, if1.out_sat, e.rnd[15:0], e.rem[16:0], e.sat);
            end
            @(negedge clk);
            checks++;
            if (if0.out_valid !== 1'b0 || busy0 !== 1'b0) begin
                errors++;
                $display("FAIL basic_idle[%0d]: vld=%b busy=%b want 0 0", i, if0.out_valid, busy0);
            end
        end
    endtask

    task automatic test_backpressure;
        int   n;
        exp_t e;
        if0.out_ready = 1'b0;
        send0(32'd24, 4'd9, 1'b1);
        wait_valid0(n);
        e = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({if0.out_valid, if0.in_ready, if0.out, if0.rem, if0.out_tag} !== {2'b10, e.root[15:0], e.rem[16:0], e.tag}) begin
                errors++;
                $display("FAIL backpressure[%0d]: vld=%b rdy=%b out=%h rem=%h tag=%h want 1 0 %h %h %h",
                         i, if0.out_valid, if0.in_ready, if0.out, if0.rem, if0.out_tag, e.root[15:0], e.rem[16:0], e.tag);
            end
            @(negedge clk);
        end
        if0.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (if0.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: out_valid=%b want 0", if0.out_valid);
        end
    endtask

    task automatic test_back_to_back;
        int   n;
        exp_t e;
        if0.out_ready = 1'b0;
        send0(32'd24, 4'd1, 1'b1);
        wait_valid0(n);
        e = sb.pop_front();
        checks++;
        if (if0.out !== e.root[15:0] || if0.out_tag !== e.tag) begin
            errors++;
            $display("FAIL b2b_first: out=%h tag=%h want %h %h", if0.out, if0.out_tag, e.root[15:0], e.tag);
        end
        if0.out_ready = 1'b1;
        if0.in_valid  = 1'b1;
        if0.in        = 32'd1000000;
        if0.in_tag    = 4'd5;
        sb.push_back(model(64'd1000000, 16, 4'd5));
        #1;
        checks++;
        if (if0.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: in_ready=%b want 1", if0.in_ready);
        end
        @(negedge clk);
        if0.in_valid = 1'b0;
        checks++;
        if (if0.out_valid !== 1'b0 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_bubble: vld=%b busy=%b want 0 1", if0.out_valid, busy0);
        end
        wait_valid0(n);
        e = sb.pop_front();
        checks++;
        if (n !== 17 || if0.out !== 16'd1000 || if0.rem !== 17'd0 || if0.out !== e.root[15:0]) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d out=%0d rem=%0d want 17 1000 0", n, if0.out, if0.rem);
        end
        @(negedge clk);
    endtask

    task automatic test_flush;
        int   n;
        exp_t e;
        if0.out_ready = 1'b1;
        send0(32'd12345, 4'd6, 1'b0);
        repeat (4) @(negedge clk);
        flush        = 1'b1;
        if0.in_valid = 1'b1;
        if0.in       = 32'd4;
        #1;
        checks++;
        if (if0.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: in_ready=%b want 0", if0.in_ready);
        end
        @(negedge clk);
        flush        = 1'b0;
        if0.in_valid = 1'b0;
        checks++;
        if (busy0 !== 1'b0 || if0.out_valid !== 1'b0 || if0.out !== 16'd1000 || if0.out_tag !== 4'd5) begin
            errors++;
            $display("FAIL flush_run: busy=%b vld=%b out=%0d tag=%0d want 0 0 1000 5", busy0, if0.out_valid, if0.out, if0.out_tag);
        end
        n = 0;
        repeat (25) begin
            @(negedge clk);
            if (if0.out_valid || busy0) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL flush_quiet: %0d active cycles want 0", n);
        end
        if0.out_ready = 1'b0;
        send0(32'd49, 4'd2, 1'b1);
        wait_valid0(n);
        e = sb.pop_front();
        checks++;
        if (if0.out !== e.root[15:0] || if0.rem !== e.rem[16:0]) begin
            errors++;
            $display("FAIL flush_pre_done: out=%h rem=%h want %h %h", if0.out, if0.rem, e.root[15:0], e.rem[16:0]);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (if0.out_valid !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL flush_done: vld=%b busy=%b want 0 0", if0.out_valid, busy0);
        end
    endtask

    task automatic test_reset_done;
        int n;
        if0.out_ready = 1'b0;
        send0(32'd81, 4'd4, 1'b0);
        wait_valid0(n);
        checks++;
        if (if0.out_valid !== 1'b1 || if0.out !== 16'd9) begin
            errors++;
            $display("FAIL rst_pre_done: vld=%b out=%0d want 1 9", if0.out_valid, if0.out);
        end
        reset        = 1'b1;
        if0.in_valid = 1'b1;
        if0.in       = 32'd16;
        #1;
        checks++;
        if (if0.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready: in_ready=%b want 0", if0.in_ready);
        end
        @(negedge clk);
        checks++;
        if ({if0.out_valid, busy0, if0.out, if0.rem, if0.out_tag, if0.out_sat, if1.out_valid, if1.out, if1.out_sat} !== '0) begin
            errors++;
            $display("FAIL rst_done: vld=%b busy=%b out=%h rem=%h tag=%h sat=%b rvld=%b rout=%h want all 0",
                     if0.out_valid, busy0, if0.out, if0.rem, if0.out_tag, if0.out_sat, if1.out_valid, if1.out);
        end
        reset        = 1'b0;
        if0.in_valid = 1'b0;
        #1;
        checks++;
        if (if0.in_ready !== 1'b1 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL rst_after: in_ready=%b busy=%b want 1 0", if0.in_ready, busy0);
        end
        @(negedge clk);
    endtask

    task automatic test_frac;
        logic [31:0] xs [2] = '{32'd2, 32'hFFFF_FFFF};
        int   n;
        exp_t e;
        if2.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (if2.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL frac_ready[%0d]: in_ready=%b want 1", i, if2.in_ready);
            end
            if2.in_valid = 1'b1;
            if2.in       = xs[i];
            if2.in_tag   = 4'(i + 3);
            q2.push_back(model(longint'(xs[i]) << 8, 20, 4'(i + 3)));
            @(negedge clk);
            if2.in_valid = 1'b0;
            n = 0;
            while (!if2.out_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
            e = q2.pop_front();
            checks++;
            if (n !== 21) begin
                errors++;
                $display("FAIL frac_latency[%0d]: got %0d want 21", i, n);
            end
            checks++;
            if ({if2.out, if2.rem, if2.out_tag} !== {e.root[19:0], e.rem[20:0], e.tag}) begin
                errors++;
                $display("FAIL frac_value[%0d]: out=%h rem=%0d tag=%0d want %h %0d %0d",
                         i, if2.out, if2.rem, if2.out_tag, e.root[19:0], e.rem[20:0], e.tag);
            end
            @(negedge clk);
        end
        checks++;
        if (sb.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d/%0d left want 0", sb.size(), q2.size());
        end
    endtask

    initial begin
        if0.in_valid  = 1'b0;
        if0.in        = '0;
        if0.in_tag    = '0;
        if0.out_ready = 1'b0;
        if2.in_valid  = 1'b0;
        if2.in        = '0;
        if2.in_tag    = '0;
        if2.out_ready = 1'b0;
        test_reset;
        test_basic;
        test_backpressure;
        test_back_to_back;
        test_flush;
        test_reset_done;
        test_frac;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
